// File: rtl/sync_frame_tx_pkg.sv
// Shared constants for the serial frame transmitter and the detector benches:
// FSM state encoding and the default sync header.
package sync_frame_tx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // Header recognised by the Moore 0101 sequence detector.
    localparam int                    DEF_SYNC_LEN = 4;
    localparam logic [DEF_SYNC_LEN-1:0] DEF_SYNC   = 4'b0101;

    // Largest of three lengths; sizes the shared bit counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_frame_tx_piso_shift.sv
// Loadable MSB-first parallel-in/serial-out shift register. The serial
// output is always the current MSB; a shift moves the next bit up and
// fills the bottom with zero.
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_en_i,
    input  logic [W-1:0] par_i,
    output logic         ser_o
);

    logic [W-1:0] sr_q;

    // Load has priority over shift; reset clears the register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= par_i;
        end else if (shift_en_i) begin
            sr_q <= sr_q << 1;
        end
    end

    assign ser_o = sr_q[W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: idle level, sync header, payload MSB-first,
// then a guard gap. Note that rst_n is active-high despite its name.
//
// Handshake: a word is accepted on a rising edge where din_valid and
// din_ready are both high. din_ready depends only on state and reset,
// never on din_valid; din is sampled only on that edge.
//
// dout is registered: the value for the next cycle is computed from the
// next state and next counter, so a new state's first bit appears in the
// first cycle of that state.
module sync_frame_tx
    import sync_frame_tx_pkg::*;
#(
    parameter int                  W          = 8,
    parameter int                  SYNC_LEN   = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC       = DEF_SYNC,
    parameter int                  GAP_LEN    = 2,
    parameter logic                IDLE_LEVEL = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         dout,
    output logic         busy,
    output logic         frame_done,
    output logic [1:0]   state_dbg
);

    localparam int MAXL = max3(SYNC_LEN, W, GAP_LEN);
    localparam int CW   = $clog2(MAXL) + 1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          fd_q, fd_d;
    logic          accept;
    logic          load, shift_en;
    logic          ser_bit;
    logic          sync_bit;

    assign din_ready = (state_q == ST_IDLE) && !rst_n;
    assign accept    = din_valid && din_ready;

    piso_shift #(.W(W)) u_piso (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .shift_en_i (shift_en),
        .par_i      (din),
        .ser_o      (ser_bit)
    );

    // State, bit counter and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= IDLE_LEVEL;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            fd_q    <= fd_d;
        end
    end

    // Next state: each phase counts to its length minus one, then moves on.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end
            end
            ST_SYNC: begin
                if (cnt_q == CW'(SYNC_LEN - 1)) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CW'(W - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(GAP_LEN - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs for the next cycle: header bit, payload MSB, or idle level.
    // The shifter advances on every edge into or within DATA, so its MSB
    // is copied to dout on the same edge that exposes the next bit.
    always_comb begin
        load     = accept;
        shift_en = (state_d == ST_DATA);
        fd_d     = (state_q == ST_DATA) && (state_d == ST_GAP);
        sync_bit = IDLE_LEVEL;
        for (int i = 0; i < SYNC_LEN; i++) begin
            if (cnt_d == CW'(SYNC_LEN - 1 - i)) sync_bit = SYNC[i];
        end
        case (state_d)
            ST_SYNC: dout_d = sync_bit;
            ST_DATA: dout_d = ser_bit;
            default: dout_d = IDLE_LEVEL;
        endcase
    end

    assign dout       = dout_q;
    assign frame_done = fd_q;
    assign busy       = (state_q != ST_IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: a cycle-accurate expectation queue filled on
// each accept, drained one entry per busy cycle, plus a Moore 0101
// detector looped back from dout.
module tb_sync_frame_tx;

  localparam int W  = 8;
  localparam int SL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       dout;
  logic       busy;
  logic       frame_done;
  logic [1:0] state_dbg;

  sync_frame_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // per-cycle expectation: {din_ready, busy, frame_done, dout}
  logic [3:0] exp_q[$];
  logic [3:0] e;
  logic [3:0] sync_c = 4'b0101;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         chk_en = 1'b0;
  bit         cur_idle = 1'b1;
  bit         det_en = 1'b0;
  int         fcyc = 0;
  int         acc_cnt = 0;
  int         det_hits = 0;
  logic [2:0] det_st = 3'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (frame cycle %0d)", tag, got, exp, fcyc);
    end
  endtask

  // model: accept decision and frame expectation, on the active edge
  always @(posedge clk) begin
    fcyc++;
    if (rst_n) begin
      exp_q.delete();
    end else if (chk_en && din_valid && cur_idle) begin
      for (int k = SL - 1; k >= 0; k--) exp_q.push_back({1'b0, 1'b1, 1'b0, sync_c[k]});
      for (int k = W - 1; k >= 0; k--) exp_q.push_back({1'b0, 1'b1, 1'b0, din[k]});
      exp_q.push_back(4'b0111);
      exp_q.push_back(4'b0101);
      acc_cnt++;
      fcyc = 1;
    end
  end

  // scoreboard compare and loopback detector, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        cur_idle = 1'b1;
        e = {!rst_n, 1'b0, 1'b0, 1'b1};
      end else begin
        cur_idle = 1'b0;
        e = exp_q.pop_front();
      end
      check("din_ready", din_ready, e[3]);
      check("busy", busy, e[2]);
      check("frame_done", frame_done, e[1]);
      check("dout", dout, e[0]);
      if (det_en && det_st == 3'd4) begin
        det_hits++;
        check("det_cycle", fcyc, 5);
      end
      case (det_st)
        3'd0: det_st = dout ? 3'd0 : 3'd1;
        3'd1: det_st = dout ? 3'd2 : 3'd1;
        3'd2: det_st = dout ? 3'd0 : 3'd3;
        3'd3: det_st = dout ? 3'd4 : 3'd1;
        default: det_st = dout ? 3'd0 : 3'd3;
      endcase
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] w, input bit keep);
    int n;
    n = acc_cnt;
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i < 40 && acc_cnt == n; i++) tick(1);
    if (!keep) din_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    din_valid = 1'b1;
    din = 8'h77;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    rst_n = 1'b0;
    din_valid = 1'b0;
    tick(3);

    // single frame
    send(8'hA5, 1'b0);
    tick(16);

    // back-to-back with din_valid held
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    tick(16);

    // din changes mid-frame are ignored
    send(8'hA5, 1'b0);
    tick(5);
    din = 8'h3C;
    tick(12);

    // reset during cycle 7, then a full new frame
    send(8'hA5, 1'b0);
    tick(6);
    rst_n = 1'b1;
    tick(1);
    rst_n = 1'b0;
    tick(3);
    send(8'h5A, 1'b0);
    tick(16);

    // loopback detector, payload 8'hFF
    det_hits = 0;
    det_en = 1'b1;
    send(8'hFF, 1'b1);
    send(8'hFF, 1'b1);
    send(8'hFF, 1'b0);
    tick(16);
    det_en = 1'b0;
    check("det_hits", det_hits, 3);

    // random words and gaps
    for (int r = 0; r < 6; r++) begin
      send(8'($urandom_range(0, 255)), 1'b0);
      tick($urandom_range(0, 20));
    end

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
